interval_timer_ctrl: RTL
========================

# interval_timer_ctrl

Controller that sequences a loadable up-counter as a programmable interval timer, in one-shot or periodic mode. It latches a period on `start`, loads the counter with the two's-complement of that period, and watches the count for all-ones. On each expiry it emits a single-cycle `tick`. In one-shot mode it then holds `done` until the consumer acknowledges. It sits between a control/CSR master and the counter datapath, and owns the counter's load and enable.

## Interface
- `WIDTH`, default 4: counter and period width in bits.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset. **One clock; reset is synchronous and active-low.**
- `start`  in  1: start request, sampled in IDLE and DONE only.
- `mode`  in  1: 0 = one-shot, 1 = periodic. Latched with `start`.
- `period`  in  WIDTH: interval in cycles. 0 encodes 2^WIDTH. Latched with `start`.
- `stop`  in  1: abort, effective in RUN.
- `ack`  in  1: clears `done`.
- `busy`  out  1: high in RUN.
- `done`  out  1: high in DONE (one-shot completed).
- `tick`  out  1: one-cycle expiry pulse.
- `count`  out  WIDTH: live counter value.

## Operation
- States:
  - IDLE: counter disabled.
  - RUN: counter enabled.
  - DONE: counter frozen.
- Load value L = (2^WIDTH − period) mod 2^WIDTH, computed on WIDTH bits. For period=0, L=0.
- Period and mode are copied into `period_q`/`mode_q` on an accepted start. Later input changes are ignored until the next start.
- Terminal condition: state==RUN and count==all-ones.
- `tick` = terminal && !stop. It is combinational from registered state and count only.
- IDLE:
  - start=1 → load L, latch period/mode, go to RUN.
  - Otherwise stay; stop and ack are ignored.
- RUN:
  - stop=1 → IDLE. Stop has priority over terminal; no tick is issued and the counter holds its value.
  - Terminal with mode_q=1 → reload L from period_q, stay in RUN.
  - Terminal with mode_q=0 → DONE, counter holds all-ones.
  - Otherwise the counter increments.
  - start is ignored in RUN.
- DONE:
  - ack=1 and start=1 → load the new L, go directly to RUN.
  - ack=1 alone → IDLE.
  - start alone is ignored.
- `count` wraps modulo 2^WIDTH. Wrap never occurs inside RUN, because reload or exit happens at all-ones.

## Timing
- Reset (rst_n low at an edge): state IDLE, count 0, period_q 0, mode_q 0. busy, done and tick are all 0 in the following cycle.
- rst_n low mid-RUN or mid-DONE: IDLE on the next edge, with no tick and no done.
- Start accepted at edge k: count = L and busy=1 from cycle k+1.
- First tick is high during the cycle after edge k+P−1, where P = period (0 → 2^WIDTH). So for P=1 the tick is high in cycle k+1.
- Periodic mode: ticks recur exactly every P cycles. For P=1, tick is continuously high.
- One-shot mode: done rises the cycle after the tick; busy falls the same cycle.
- done stays high until an edge with ack=1; it is low the cycle after.
- Latency from stop to busy low: 1 cycle.

## Structure
- Package `interval_timer_pkg`:
  - State enum `tmr_state_t` with IDLE, RUN, DONE.
  - Constants `MODE_ONESHOT`=0 and `MODE_PERIODIC`=1.
- Sub-module `load_up_counter`: WIDTH-bit, with clk, rst_n (synchronous, active-low), en, ld, ldvalue, dout. Priority is reset > ld > en.
- The controller contains the FSM, the period/mode latches, load-value arithmetic, terminal detect and output decode.

## Test plan
- Reset: assert rst_n=0 for 2 cycles mid-RUN with period=5 → count=0, busy=0, done=0, tick=0 the cycle after the first low edge.
- One-shot, period=3, WIDTH=4: start at edge k → count 13,14,15. Tick only in cycle k+3; done=1 from k+4; ack at k+6 → done=0 at k+7.
- Periodic, period=4: ticks at cycles k+4, k+8, k+12. Changing period to 2 mid-run does not change the spacing. Stop at k+10 → busy=0 at k+11, no further ticks.
- Boundaries:
  - period=1 periodic → tick high every cycle.
  - period=0 periodic → L=0, ticks spaced 16 cycles.
- Simultaneous events:
  - stop in the terminal cycle → no tick, IDLE.
  - start+ack in DONE with period=2 → RUN next cycle, count=14, tick one cycle later.
- Ignored inputs: start during RUN → no reload. start during DONE without ack → stays in DONE.

Source files
------------

// File: rtl/interval_timer_ctrl_pkg.sv
// Shared types for the interval timer: controller state encoding and mode constants.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package interval_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tmr_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between a CSR master and the interval timer controller.
// Latency: n/a (wiring only).
// Backpressure: none; start/stop/ack are level requests and status is always valid.
//   master: drives start, mode, period, stop, ack; observes busy, done, tick, count
//   slave : the inverse
interface interval_timer_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] period;
    logic             stop;
    logic             ack;
    logic             busy;
    logic             done;
    logic             tick;
    logic [WIDTH-1:0] count;

    modport master (
        output start, mode, period, stop, ack,
        input  busy, done, tick, count
    );

    modport slave (
        input  start, mode, period, stop, ack,
        output busy, done, tick, count
    );
endinterface

// File: rtl/load_up_counter.sv
// Loadable WIDTH-bit up-counter; reset > load > enable, wraps modulo 2^WIDTH.
// Latency: load or increment visible one cycle after the edge that samples it.
// Backpressure: none; holds its value whenever neither ld nor en is asserted.
//   clk, rst_n (sync, active-low), en, ld, ldvalue in; dout out
module load_up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ldvalue,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (ld) begin
            dout_q <= ldvalue;
        end else if (en) begin
            dout_q <= dout_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: sequences a loadable up-counter in one-shot or periodic mode.
// Latency: busy/count one cycle after start; first tick P cycles after start; done one cycle after tick.
// Backpressure: done is held until ack; start is ignored while RUN or while DONE without ack.
//   clk, rst_n (sync, active-low) plain ports; bus (slave) carries start/mode/period/stop/ack
//   in and busy/done/tick/count out.
module interval_timer_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    interval_timer_ctrl_if.slave bus
);
    import interval_timer_pkg::*;

    tmr_state_t       state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;

    logic             cnt_ld;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_ldvalue;
    logic [WIDTH-1:0] cnt_dout;

    logic [WIDTH-1:0] load_new;
    logic [WIDTH-1:0] load_held;
    logic             terminal;

    // Counting up from -P reaches all-ones after exactly P-1 increments, so
    // the terminal cycle is the P-th cycle of the interval. Period 0 gives a
    // load of 0, i.e. a full 2^WIDTH interval, with no special casing.
    assign load_new  = {WIDTH{1'b0}} - bus.period;
    assign load_held = {WIDTH{1'b0}} - period_q;

    assign terminal  = (state_q == RUN) && (cnt_dout == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        mode_d      = mode_q;
        cnt_ld      = 1'b0;
        cnt_en      = 1'b0;
        cnt_ldvalue = load_held;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_ld      = 1'b1;
                    cnt_ldvalue = load_new;
                    period_d    = bus.period;
                    mode_d      = bus.mode;
                    state_d     = RUN;
                end
            end

            RUN: begin
                // Stop wins over expiry: leave with the counter frozen.
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (terminal) begin
                    if (mode_q == MODE_PERIODIC) begin
                        // Reload from the latched period so mid-run input
                        // changes cannot alter the spacing.
                        cnt_ld = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end

            DONE: begin
                if (bus.ack && bus.start) begin
                    cnt_ld      = 1'b1;
                    cnt_ldvalue = load_new;
                    period_d    = bus.period;
                    mode_d      = bus.mode;
                    state_d     = RUN;
                end else if (bus.ack) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    load_up_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (cnt_en),
        .ld      (cnt_ld),
        .ldvalue (cnt_ldvalue),
        .dout    (cnt_dout)
    );

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.tick  = terminal && !bus.stop;
    assign bus.count = cnt_dout;

endmodule
